// File: rtl/vga_pixel_store.sv
// vga_pixel_store
//   Low-resolution frame buffer between the VGA timing controller and the
//   video DAC. Each buffer cell covers a 2^SCALE_LOG2 x 2^SCALE_LOG2 block of
//   screen pixels. The buffer is a single-port RAM: the pixel read owns it
//   during the active region, and writer/clear traffic owns it during blanking.
//
// Ports
//   vgaclk, reset           pixel clock, synchronous active-high reset
//   vgaX, vgaY              current pixel position from the timing controller
//   hsync_in, vsync_in      active-low syncs from the controller
//   blank_b_in              high inside the visible 640x480 region
//   wr_valid/wr_ready       writer handshake (accepted only during blanking)
//   wr_x, wr_y, wr_color    cell column/row and RGB111 colour to write
//   clr_req, clr_busy       clear-whole-buffer request pulse and busy flag
//   r, g, b                 8-bit colour to the DAC (zero while blanked)
//   hsync_out, vsync_out,
//   blank_b_out             controller signals delayed to align with r/g/b
module vga_pixel_store #(
  parameter int SCALE_LOG2 = 2,
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int CW         = 3
) (
  input  logic          vgaclk,
  input  logic          reset,
  input  logic [9:0]    vgaX,
  input  logic [9:0]    vgaY,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          blank_b_in,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_x,
  input  logic [6:0]    wr_y,
  input  logic [CW-1:0] wr_color,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          blank_b_out
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]    state_reg;
  logic [AW-1:0] clr_cnt_reg;

  // ---------------------------------------------------------------------
  // Address generation. Row * 160 is built from two shifts (128 + 32) so
  // the multiply stays in fabric adders.
  // ---------------------------------------------------------------------
  logic [AW-1:0] rd_row, rd_col, rd_addr;
  logic [AW-1:0] wr_row, wr_col, wr_addr;

  assign rd_row  = AW'(vgaY >> SCALE_LOG2);
  assign rd_col  = AW'(vgaX >> SCALE_LOG2);
  assign rd_addr = (rd_row << 7) + (rd_row << 5) + rd_col;

  assign wr_row  = AW'(wr_y);
  assign wr_col  = AW'(wr_x);
  assign wr_addr = (wr_row << 7) + (wr_row << 5) + wr_col;

  // ---------------------------------------------------------------------
  // Port arbitration
  // ---------------------------------------------------------------------
  logic wr_in_range;
  logic wr_fire;
  logic clr_write;
  logic ram_we;
  logic [AW-1:0] ram_addr;
  logic [CW-1:0] ram_wdata;

  assign wr_ready    = (state_reg == ST_IDLE) & ~blank_b_in & ~reset;
  assign clr_busy    = (state_reg == ST_CLEAR);
  assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
  // Out-of-range writes still complete the handshake, they just never
  // reach the RAM.
  assign wr_fire     = wr_valid & wr_ready;
  assign clr_write   = (state_reg == ST_CLEAR) & ~blank_b_in;
  assign ram_we      = clr_write | (wr_fire & wr_in_range);

  always_comb begin
    ram_addr  = wr_addr;
    ram_wdata = wr_color;
    if (blank_b_in) begin
      ram_addr = rd_addr;
    end else if (state_reg == ST_CLEAR) begin
      ram_addr  = clr_cnt_reg;
      ram_wdata = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Single-port RAM with registered read. Reads are only issued in the
  // active region, where the address is always inside the buffer.
  // ---------------------------------------------------------------------
  logic [CW-1:0] mem [0:DEPTH-1];
  logic [CW-1:0] rd_data_reg;

  always_ff @(posedge vgaclk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end else if (blank_b_in) begin
      rd_data_reg <= mem[ram_addr];
    end
  end

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      clr_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (clr_req) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
          end
        end
        ST_CLEAR: begin
          // Counter only advances on cycles where the clear owns the RAM.
          if (!blank_b_in) begin
            if (clr_cnt_reg == LAST_ADDR) begin
              state_reg   <= ST_IDLE;
              clr_cnt_reg <= '0;
            end else begin
              clr_cnt_reg <= clr_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          clr_cnt_reg <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output pipeline. Stage 1 runs in parallel with the RAM read; stage 2
  // registers the expanded colour together with the delayed syncs.
  // ---------------------------------------------------------------------
  logic hsync_d1_reg, vsync_d1_reg, blank_d1_reg;
  logic hsync_d2_reg, vsync_d2_reg, blank_d2_reg;
  logic [7:0] r_reg, g_reg, b_reg;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      hsync_d1_reg <= 1'b1;
      vsync_d1_reg <= 1'b1;
      blank_d1_reg <= 1'b0;
      hsync_d2_reg <= 1'b1;
      vsync_d2_reg <= 1'b1;
      blank_d2_reg <= 1'b0;
      r_reg        <= 8'h00;
      g_reg        <= 8'h00;
      b_reg        <= 8'h00;
    end else begin
      hsync_d1_reg <= hsync_in;
      vsync_d1_reg <= vsync_in;
      blank_d1_reg <= blank_b_in;
      hsync_d2_reg <= hsync_d1_reg;
      vsync_d2_reg <= vsync_d1_reg;
      blank_d2_reg <= blank_d1_reg;
      // Gating by the stage-1 blank keeps stale RAM data (from blanking
      // cycles where no read happened) off the DAC.
      r_reg <= (blank_d1_reg & rd_data_reg[2]) ? 8'hFF : 8'h00;
      g_reg <= (blank_d1_reg & rd_data_reg[1]) ? 8'hFF : 8'h00;
      b_reg <= (blank_d1_reg & rd_data_reg[0]) ? 8'hFF : 8'h00;
    end
  end

  assign r           = r_reg;
  assign g           = g_reg;
  assign b           = b_reg;
  assign hsync_out   = hsync_d2_reg;
  assign vsync_out   = vsync_d2_reg;
  assign blank_b_out = blank_d2_reg;

endmodule

// File: doc/vga_pixel_store.md
Name: vga_pixel_store

Overview:
- Pixel-domain frame buffer between the VGA timing controller and the video DAC pins.
- Takes the controller's vgaX/vgaY and sync/blank, reads a low-resolution colour buffer, and emits 8-bit r/g/b with the syncs delayed to stay aligned.
- A writer (game/draw logic) updates pixels through a valid/ready port that only accepts writes during blanking.
- Provides a hardware clear sequencer.

Parameters:
- SCALE_LOG2, 2, screen pixels per buffer cell = 2^SCALE_LOG2 in x and y (4x4)
- FB_W, 160, buffer width in cells
- FB_H, 120, buffer height in cells
- CW, 3, colour bits per cell, RGB111 (bit2=R, bit1=G, bit0=B)

Ports:
- vgaclk  in  1  25.175 MHz pixel clock; only clock
- reset  in  1  synchronous, active-high
- vgaX  in  10  current pixel column from timing controller
- vgaY  in  10  current pixel row
- hsync_in  in  1  active-low hsync from controller
- vsync_in  in  1  active-low vsync from controller
- blank_b_in  in  1  high in the 640x480 active region
- wr_valid  in  1  writer request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_x  in  8  cell column
- wr_y  in  7  cell row
- wr_color  in  CW  cell colour
- clr_req  in  1  single-cycle pulse: start clearing the whole buffer to 0
- clr_busy  out  1  high while clearing
- r, g, b  out  8 each  to video DAC
- hsync_out, vsync_out  out  1  delayed syncs to monitor
- blank_b_out  out  1  delayed blank to DAC

Behaviour:
- Storage: FB_W*FB_H x CW single-port synchronous RAM, one access per cycle.
- Cell address = (y>>SCALE_LOG2)*FB_W + (x>>SCALE_LOG2). Implement the multiply by 160 as (y<<7)+(y<<5); no DSP.
- Port arbitration:
  - blank_b_in=1: the read owns the RAM.
  - blank_b_in=0: a write or a clear owns it.
  - A read is never stalled.
- Read pipeline:
  - Address is registered at cycle t; RAM data is valid at t+1; r/g/b are registered at t+2.
  - hsync, vsync and blank_b each pass through a 2-stage delay, so their outputs align with r/g/b.
- Colour expansion: each colour bit maps to 8'hFF when 1 and 8'h00 when 0. r/g/b are forced to 0 whenever blank_b_out=0.
- Write port:
  - wr_ready = (state==IDLE) & ~blank_b_in & ~reset.
  - On transfer, the RAM is written in the same cycle.
  - wr_x>=FB_W or wr_y>=FB_H: the transfer is accepted (handshake completes) but no RAM write occurs.
  - The writer must hold wr_x, wr_y, wr_color and wr_valid stable until the transfer completes.
- FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req=1. The clear counter loads 0 and clr_busy goes high the next cycle.
  - CLEAR: each cycle with blank_b_in=0, write 0 at the counter address and increment the counter. With blank_b_in=1 the counter holds.
  - CLEAR -> IDLE on the cycle after the write to address FB_W*FB_H-1. clr_busy goes low in the same cycle as the IDLE transition.
  - clr_req while in CLEAR is ignored.
  - clr_req and a write transfer in the same IDLE cycle: the write completes, then the clear starts and overwrites it.
  - A full clear needs 19200 blanking cycles, under one frame (112800 blanking cycles per frame).
- Reset values: r=g=b=0, hsync_out=1, vsync_out=1, blank_b_out=0, wr_ready=0, clr_busy=0, state=IDLE, counter=0, delay stages hsync/vsync=1 and blank_b=0.
- RAM contents are not initialised by reset.
- Reset during CLEAR returns to IDLE with the buffer partially cleared. Software must issue clr_req again.

Test Plan:
- Reset held 3 cycles with toggling inputs -> r/g/b=0, syncs=1, blank_b_out=0, wr_ready=0, clr_busy=0 throughout.
- clr_req, then run until clr_busy falls -> fall occurs within one frame; any active pixel thereafter gives r=g=b=00.
- During blanking, write cell (5,3)=3'b100 -> at vgaX 20..23, vgaY 12..15, outputs r=FF, g=00, b=00 exactly 2 cycles after that vgaX is presented; neighbouring pixels stay 00.
- wr_valid held starting mid active line -> wr_ready=0 until blank_b_in falls, then exactly one transfer; write of wr_x=160 is accepted but leaves the buffer unchanged.
- Sync alignment -> hsync_out/vsync_out/blank_b_out equal the inputs delayed by exactly 2 cycles over a full frame; r/g/b=0 whenever blank_b_out=0.
- Reset asserted at clear counter ~5000 -> clr_busy=0 the next cycle, wr_ready returns in blanking; a new clr_req completes a full clear.
